// File: rtl/grid_board_ctrl.sv
// Cat Trap 8x8 board state: debounced cursor/placement and LFSR block seeding.
// Optional CURSOR_WRAP_EN: cursor wraps at edges (default build saturates).
module grid_board_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 1_000_000,
  parameter int          INIT_BLOCKS     = 10,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnL,
  input  logic        BtnR,
  input  logic        BtnC,
  input  logic        start_seed,
  input  logic        enable,
  input  logic [5:0]  cat_idx,
  output logic [63:0] blocked,
  output logic [2:0]  cursor_row,
  output logic [2:0]  cursor_col,
  output logic        busy,
  output logic        place_pulse,
  output logic [5:0]  place_idx,
  output logic        reject_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [5:0] INIT_CNT = 6'(INIT_BLOCKS);

  localparam int BC = 0;
  localparam int BU = 1;
  localparam int BD = 2;
  localparam int BL = 3;
  localparam int BR = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEED  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t        state;
  logic [5:0]    remaining;
  logic [15:0]   lfsr;
  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    stable;
  logic [4:0]    stable_q;
  logic [CW-1:0] cnt [5];
  logic [4:0]    press;
  logic [4:0]    pick;
  logic [5:0]    cand;
  logic [5:0]    idx;
  logic [2:0]    row_up;
  logic [2:0]    row_dn;
  logic [2:0]    col_lf;
  logic [2:0]    col_rt;

  assign raw = {BtnR, BtnL, BtnD, BtnU, BtnC};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Rising edges only; lowest set bit wins, so C beats U beats D ...
  assign press = stable & ~stable_q;
  assign pick  = press & (~press + 5'd1);

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign cand = lfsr[5:0];
  assign idx  = {cursor_row, cursor_col};

`ifdef CURSOR_WRAP_EN
  assign row_up = cursor_row - 3'd1;
  assign row_dn = cursor_row + 3'd1;
  assign col_lf = cursor_col - 3'd1;
  assign col_rt = cursor_col + 3'd1;
`else
  assign row_up = (cursor_row == 3'd0) ? cursor_row : cursor_row - 3'd1;
  assign row_dn = (cursor_row == 3'd7) ? cursor_row : cursor_row + 3'd1;
  assign col_lf = (cursor_col == 3'd0) ? cursor_col : cursor_col - 3'd1;
  assign col_rt = (cursor_col == 3'd7) ? cursor_col : cursor_col + 3'd1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= '0;
      blocked      <= '0;
      cursor_row   <= 3'd3;
      cursor_col   <= 3'd3;
      busy         <= 1'b0;
      place_pulse  <= 1'b0;
      reject_pulse <= 1'b0;
      place_idx    <= '0;
    end else begin
      place_pulse  <= 1'b0;
      reject_pulse <= 1'b0;
      if (start_seed) begin
        blocked    <= '0;
        cursor_row <= 3'd3;
        cursor_col <= 3'd3;
        remaining  <= INIT_CNT;
        if (INIT_CNT == 6'd0) begin
          state <= READY;
          busy  <= 1'b0;
        end else begin
          state <= SEED;
          busy  <= 1'b1;
        end
      end else begin
        unique case (state)
          IDLE: ;
          SEED: begin
            if (!blocked[cand] && cand != cat_idx) begin
              blocked[cand] <= 1'b1;
              remaining     <= remaining - 6'd1;
              if (remaining == 6'd1) begin
                state <= READY;
                busy  <= 1'b0;
              end
            end
          end
          READY: begin
            if (enable) begin
              unique case (1'b1)
                pick[BC]: begin
                  if (!blocked[idx] && idx != cat_idx) begin
                    blocked[idx] <= 1'b1;
                    place_pulse  <= 1'b1;
                    place_idx    <= idx;
                  end else begin
                    reject_pulse <= 1'b1;
                  end
                end
                pick[BU]: cursor_row <= row_up;
                pick[BD]: cursor_row <= row_dn;
                pick[BL]: cursor_col <= col_lf;
                pick[BR]: cursor_col <= col_rt;
                default: ;
              endcase
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grid_board_ctrl.sv
// Bench for grid_board_ctrl: random and directed button/seed stimulus
// compared every cycle against a behavioural board model.
module tb_grid_board_ctrl;

  localparam int          DB   = 4;
  localparam int          IB   = 10;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [31:0] MASK = (32'd1 << DB) - 32'd1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  btn = '0;
  logic        start_seed = 1'b0;
  logic        enable = 1'b0;
  logic [5:0]  cat_idx = 6'd27;
  logic [63:0] blocked;
  logic [2:0]  cursor_row;
  logic [2:0]  cursor_col;
  logic        busy;
  logic        place_pulse;
  logic [5:0]  place_idx;
  logic        reject_pulse;

  grid_board_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .INIT_BLOCKS(IB),
    .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .reset(reset),
    .BtnU(btn[1]),
    .BtnD(btn[2]),
    .BtnL(btn[3]),
    .BtnR(btn[4]),
    .BtnC(btn[0]),
    .start_seed(start_seed),
    .enable(enable),
    .cat_idx(cat_idx),
    .blocked(blocked),
    .cursor_row(cursor_row),
    .cursor_col(cursor_col),
    .busy(busy),
    .place_pulse(place_pulse),
    .place_idx(place_idx),
    .reject_pulse(reject_pulse)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  // Behavioural model state
  bit [63:0]   m_blocked = '0;
  int          m_row = 3;
  int          m_col = 3;
  int          m_pidx = 0;
  int          m_rem = 0;
  bit          m_busy = 0;
  bit          m_pp = 0;
  bit          m_rp = 0;
  bit          m_started = 0;
  bit [15:0]   m_lfsr = SEED;
  bit          sy1 [5];
  bit          sy2 [5];
  bit          stb [5];
  bit          rose [5];
  logic [31:0] hv [5];

  function automatic int dec(input int v);
`ifdef CURSOR_WRAP_EN
    return (v + 7) % 8;
`else
    return (v > 0) ? v - 1 : v;
`endif
  endfunction

  function automatic int inc(input int v);
`ifdef CURSOR_WRAP_EN
    return (v + 1) % 8;
`else
    return (v < 7) ? v + 1 : v;
`endif
  endfunction

  task automatic model_step();
    bit [4:0] pr;
    int       cand;
    int       idx;
    for (int b = 0; b < 5; b++) pr[b] = rose[b];
    // a level is accepted after DB consecutive synced samples disagree
    for (int b = 0; b < 5; b++) begin
      hv[b] = {hv[b][30:0], sy2[b]};
      rose[b] = 1'b0;
      if ((hv[b] & MASK) == (stb[b] ? 32'd0 : MASK)) begin
        stb[b] = ~stb[b];
        rose[b] = stb[b];
      end
      sy2[b] = sy1[b];
      sy1[b] = btn[b];
    end
    m_pp = 0;
    m_rp = 0;
    cand = int'(m_lfsr[5:0]);
    if (start_seed) begin
      m_blocked = '0;
      m_row = 3;
      m_col = 3;
      m_rem = IB;
      m_busy = (IB != 0);
      m_started = 1;
    end else if (m_busy) begin
      if (!m_blocked[cand] && cand != int'(cat_idx)) begin
        m_blocked[cand] = 1'b1;
        m_rem--;
        if (m_rem == 0) m_busy = 0;
      end
    end else if (m_started && enable) begin
      if (pr[0]) begin
        idx = m_row * 8 + m_col;
        if (!m_blocked[idx] && idx != int'(cat_idx)) begin
          m_blocked[idx] = 1'b1;
          m_pp = 1;
          m_pidx = idx;
        end else begin
          m_rp = 1;
        end
      end else if (pr[1]) m_row = dec(m_row);
      else if (pr[2]) m_row = inc(m_row);
      else if (pr[3]) m_col = dec(m_col);
      else if (pr[4]) m_col = inc(m_col);
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic check_all();
    chk("blocked", blocked, m_blocked);
    chk("row", 64'(cursor_row), 64'(m_row));
    chk("col", 64'(cursor_col), 64'(m_col));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("place_pulse", 64'(place_pulse), 64'(m_pp));
    chk("reject_pulse", 64'(reject_pulse), 64'(m_rp));
    chk("place_idx", 64'(place_idx), 64'(m_pidx));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic hold(input logic [4:0] b);
    btn = b;
    repeat (DB + 3) step();
  endtask

  task automatic release_all();
    btn = '0;
    repeat (DB + 4) step();
  endtask

  task automatic pulse_seed();
    start_seed = 1'b1;
    step();
    start_seed = 1'b0;
  endtask

  task automatic wait_seed(input string tag);
    for (int i = 0; i < 2000 && busy; i++) step();
    chk({tag, "_done"}, 64'(busy), 64'd0);
    chk({tag, "_count"}, 64'($countones(blocked)), 64'(IB));
    chk({tag, "_cat"}, 64'(blocked[cat_idx]), 64'd0);
  endtask

  bit free28;
  int exp_row;
  int exp_col;
  bit [63:0] saved;

  initial begin
    for (int b = 0; b < 5; b++) begin
      sy1[b] = 0;
      sy2[b] = 0;
      stb[b] = 0;
      rose[b] = 0;
      hv[b] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    start_seed = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_seed = 1'b0;
    chk("rst_blocked", blocked, 64'd0);
    chk("rst_row", 64'(cursor_row), 64'd3);
    chk("rst_col", 64'(cursor_col), 64'd3);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pulses", 64'({place_pulse, reject_pulse}), 64'd0);
    chk("rst_pidx", 64'(place_idx), 64'd0);

    cat_idx = 6'd27;
    pulse_seed();
    chk("seed_busy", 64'(busy), 64'd1);
    wait_seed("seed");
    enable = 1'b1;

    saved = m_blocked;
    hold(5'b00001);
    chk("c_on_cat", 64'(reject_pulse), 64'd1);
    chk("c_on_cat_pp", 64'(place_pulse), 64'd0);
    chk("c_on_cat_board", blocked, saved);
    release_all();

    btn = 5'b10000;
    repeat (DB + 2) step();
    chk("r_early", 64'(cursor_col), 64'd3);
    step();
    chk("r_latency", 64'(cursor_col), 64'd4);
    repeat (20) step();
    chk("r_held", 64'(cursor_col), 64'd4);
    release_all();

    free28 = !m_blocked[28];
    hold(5'b00001);
    chk("c28_place", 64'(place_pulse), 64'(free28));
    chk("c28_reject", 64'(reject_pulse), 64'(!free28));
    if (free28) chk("c28_idx", 64'(place_idx), 64'd28);
    chk("c28_set", 64'(blocked[28]), 64'd1);
    release_all();
    hold(5'b00001);
    chk("c28_again", 64'(reject_pulse), 64'd1);
    release_all();

    for (int i = 0; i < 5; i++) begin
      btn = 5'b00010;
      repeat (2) step();
      btn = '0;
      repeat (2) step();
    end
    repeat (10) step();
    chk("glitch_row", 64'(cursor_row), 64'd3);

    repeat (3) begin
      hold(5'b00010);
      release_all();
    end
    repeat (3) begin
      hold(5'b10000);
      release_all();
    end
    chk("corner_row", 64'(cursor_row), 64'd0);
    chk("corner_col", 64'(cursor_col), 64'd7);
    hold(5'b00010);
    release_all();
    hold(5'b10000);
    release_all();
`ifdef CURSOR_WRAP_EN
    exp_row = 7;
    exp_col = 0;
`else
    exp_row = 0;
    exp_col = 7;
`endif
    chk("edge_row", 64'(cursor_row), 64'(exp_row));
    chk("edge_col", 64'(cursor_col), 64'(exp_col));

    enable = 1'b0;
    hold(5'b01000);
    release_all();
    chk("disabled_col", 64'(cursor_col), 64'(exp_col));
    enable = 1'b1;

    hold(5'b01001);
    chk("cl_c_wins", 64'(place_pulse | reject_pulse), 64'd1);
    chk("cl_col", 64'(cursor_col), 64'(exp_col));
    release_all();

    pulse_seed();
    for (int i = 0; i < 500 && $countones(m_blocked) < 5; i++) step();
    chk("mid_five", 64'($countones(blocked)), 64'd5);
    pulse_seed();
    chk("restart_clear", blocked, 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    wait_seed("restart");

    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 9) < 6) btn = 5'(1 << $urandom_range(0, 4));
      else if ($urandom_range(0, 1) == 0) btn = '0;
      else btn = 5'($urandom);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) cat_idx = 6'($urandom);
      if ($urandom_range(0, 39) == 0) pulse_seed();
      repeat ($urandom_range(1, 12)) step();
    end
    release_all();
    for (int i = 0; i < 2000 && busy; i++) step();
    chk("final_idle", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/grid_board_ctrl.md
Name: grid_board_ctrl

Overview:
- Owns the 8x8 Cat Trap board state and feeds the VGA grid renderer, which consumes `blocked`, `cursor_row` and `cursor_col` to colour cells white, gray or highlighted.
- Debounces the raw push-buttons, moves a selection cursor and places gray blocks on BtnC.
- Seeds a configurable number of pseudo-random initial blocks when a new game starts.
- Upstream of the renderer; the game-level FSM drives `start_seed` and `enable`, and supplies `cat_idx`.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronized samples required to accept a button level change (4 in simulation).
- INIT_BLOCKS, 10: blocks seeded per new game; legal range 0..32.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- BtnU, BtnD, BtnL, BtnR, BtnC  in  1 each  raw asynchronous buttons.
- start_seed  in  1  one-cycle pulse from the game FSM; clears the board and starts seeding.
- enable  in  1  high while the game FSM is in PLAY; gates cursor moves and placement.
- cat_idx  in  6  current cat cell, encoded as row*8+col.
- blocked  out  64  bit i set = cell i is a gray block.
- cursor_row, cursor_col  out  3 each  selected cell; row 0 is top, col 0 is left.
- busy  out  1  high while seeding.
- place_pulse  out  1  one cycle; a block was just placed.
- place_idx  out  6  cell placed; valid with `place_pulse`, otherwise holds its last value.
- reject_pulse  out  1  one cycle; a BtnC placement was refused.

Behaviour:
- Reset values: state IDLE, blocked=0, cursor=(3,3), busy=0, place_pulse=0, reject_pulse=0, place_idx=0, lfsr=LFSR_SEED, all debouncers stable-low with counters at 0.
- Button path, per button:
  - 2-FF synchronizer.
  - Debounce counter increments while sync != stable and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync != stable, `stable` takes `sync` and the counter clears.
  - A press is the combinational rising edge of `stable`; releases generate nothing.
  - Latency: raw held high from edge 0 gives a registered action result after edge DEBOUNCE_CYCLES+3.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in every state, including IDLE.
- FSM:
  - IDLE: ignores presses. `start_seed` goes to SEED, or to READY if INIT_BLOCKS=0.
  - SEED: busy=1; presses are ignored and dropped. Each cycle the candidate is lfsr[5:0]. If the candidate is not blocked and != cat_idx, set its bit and decrement the remaining count; otherwise retry next cycle. When remaining reaches 0, go to READY on the same edge as the last set.
  - READY: acts on at most one press per cycle, with priority C > U > D > L > R. Lower-priority presses in the same cycle are discarded, not queued. If enable=0, all presses are discarded.
- Any state: `start_seed` clears blocked to 0, sets cursor to (3,3) and loads remaining=INIT_BLOCKS. This also applies mid-seed, where it restarts the count.
- `start_seed` and `reset` in the same cycle: reset wins.
- Cursor moves in READY: U decrements row, D increments row, L decrements col, R increments col. Edge behaviour is set by the optional feature below.
- Placement on BtnC: idx = {cursor_row, cursor_col}.
  - If blocked[idx]=0 and idx != cat_idx: set blocked[idx], place_pulse=1, place_idx=idx on the next edge.
  - Otherwise: reject_pulse=1 and blocked is unchanged.
  - place_pulse and reject_pulse are never high together.
- `cat_idx` is sampled in the same cycle as the decision. A `cat_idx` change coincident with a press uses the pre-edge value.
- Full board: placement attempts only reject; no lockup.

Optional Feature:
- CURSOR_WRAP_EN defined: a cursor move past an edge wraps, e.g. U at row 0 goes to row 7 and R at col 7 goes to col 0.
- CURSOR_WRAP_EN undefined: the cursor saturates at 0 and 7, and the press is consumed with no change.

Test Plan:
- Reset, then DEBOUNCE_CYCLES=4 and INIT_BLOCKS=0, pulse start_seed, enable=1, hold BtnR high -> cursor_col goes 3->4 exactly 7 clocks after the raw rise; holding longer gives no further moves.
- Toggle BtnU with 2-cycle glitches (shorter than DEBOUNCE_CYCLES) -> cursor unchanged, no pulses.
- INIT_BLOCKS=10, cat_idx=27, pulse start_seed -> busy high until popcount(blocked)=10, blocked[27]=0, then READY.
- Cursor at (3,3), cat_idx=27, press BtnC -> reject_pulse=1, blocked unchanged. Move R then press C -> place_pulse=1, place_idx=28, blocked[28]=1. Press C again -> reject_pulse.
- Cursor at (0,7), press U then R -> with CURSOR_WRAP_EN, cursor=(7,0); without it, (0,7).
- Pulse start_seed mid-seed after 5 blocks placed -> blocked cleared that edge, then exactly INIT_BLOCKS bits set. BtnC and BtnL debounced in the same cycle -> only the C action occurs.
